// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the main-memory port arbiter:
//     - arb_state_t : access sequencer states (IDLE, ISSUE, WAIT, DONE)
//     - RD / WR     : values of the rw command bit
//     - P0 / P1     : port indices as carried in grant signals
//     - other_port(): the port that is not the given one
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    // One memory access walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // rw command encoding, shared by both ports and the memory interface.
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Port indices. A single bit is enough to name either requester.
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    function automatic logic other_port(input logic port);
        return (port == P0) ? P1 : P0;
    endfunction

endpackage : mem_arb_pkg

// File: rtl/arb_pick2.sv
// -----------------------------------------------------------------------------
// arb_pick2
//   Combinational two-way request picker.
//
//   Build option:
//     ARB_ROUND_ROBIN_EN defined   : when both ports request, grant the port
//                                    that did not win last time (i_last_gnt).
//     ARB_ROUND_ROBIN_EN undefined : fixed priority, port 0 wins every contest.
//   A lone requester is always granted.
//
//   Ports:
//     i_req[1:0]  in   request vector, bit n = port n
//     i_last_gnt  in   port granted most recently
//     o_gnt       out  selected port (meaningful only when o_valid)
//     o_valid     out  at least one request present
// -----------------------------------------------------------------------------
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic       o_gnt,
    output logic       o_valid
);

    // NOTE: every output of an always_comb block gets a default on entry, so
    // no path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        o_valid = |i_req;
        // With no request the grant is a don't-care; echoing the previous
        // winner keeps the output quiet instead of toggling.
        o_gnt   = i_last_gnt;
        case (i_req)
            2'b01:   o_gnt = P0;
            2'b10:   o_gnt = P1;
`ifdef ARB_ROUND_ROBIN_EN
            2'b11:   o_gnt = other_port(i_last_gnt);
`else
            2'b11:   o_gnt = P0;
`endif
            default: o_gnt = i_last_gnt;
        endcase
    end

endmodule : arb_pick2

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-ported main memory between two requesters:
//     port 0 : control unit fetch / LW / SW path
//     port 1 : I/O loader / DMA path
//   Each port uses a req/done handshake. The arbiter owns the memory control
//   and address/data lines, runs one access at a time, waits out the fixed
//   memory latency and returns captured read data to the granted port.
//
//   Build option: ARB_ROUND_ROBIN_EN (see arb_pick2) selects round-robin
//   instead of fixed port-0 priority for simultaneous requests.
//
//   Parameters:
//     ADDR_W   memory word-address width
//     DATA_W   data word width
//     MEM_LAT  cycles from address/control presented to read data valid
//              (or write committed); must be >= 1
//
//   Ports:
//     clk, reset            rising-edge clock, synchronous active-high reset
//     pN_req                request, held high with stable command until pN_done
//     pN_rw                 0 = read, 1 = write
//     pN_addr / pN_wdata    word address / write data
//     pN_rdata              read data, valid in the pN_done cycle, held until
//                           the next port-N read completes
//     pN_done               one-cycle completion pulse
//     mem_e / mem_rw        memory enable / direction (mem_rw is 0 unless an
//                           access is being presented)
//     mem_addr / mem_wdata  memory address / write data
//     mem_rdata             memory read data
//
//   Timing: a request sampled in IDLE cycle N completes with pN_done in cycle
//   N + MEM_LAT + 2. Requests are only looked at in IDLE; a losing port stays
//   pending and is served on a later IDLE cycle.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,

    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,

    output logic              mem_e,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter only ever runs 1..MEM_LAT, so this width never wraps.
    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

    // -------------------------------------------------------------------------
    // State and hold registers
    // -------------------------------------------------------------------------
    arb_state_t        r_state;
    arb_state_t        w_state_next;

    logic              r_gnt;        // port owning the access in flight
    logic              r_last_gnt;   // most recent winner, feeds round-robin
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic              w_pick_gnt;
    logic              w_pick_valid;
    logic              w_take;       // IDLE and someone is asking
    logic              w_lat_hit;    // memory data valid this cycle
    logic              w_mem_en;
    logic              w_done;

    logic              w_sel_rw;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // -------------------------------------------------------------------------
    // Request selection
    // -------------------------------------------------------------------------
    arb_pick2 u_pick (
        .i_req      ({p1_req, p0_req}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_pick_gnt),
        .o_valid    (w_pick_valid)
    );

    assign w_take      = (r_state == IDLE) && w_pick_valid;
    assign w_lat_hit   = (r_cnt == CNT_LAST);

    assign w_sel_rw    = (w_pick_gnt == P1) ? p1_rw    : p0_rw;
    assign w_sel_addr  = (w_pick_gnt == P1) ? p1_addr  : p0_addr;
    assign w_sel_wdata = (w_pick_gnt == P1) ? p1_wdata : p0_wdata;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_mem_en     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_mem_en     = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                w_mem_en = 1'b1;
                if (w_lat_hit) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: command hold registers, latency counter, read-data capture
    // -------------------------------------------------------------------------
    // Commands are copied into hold registers when sampled so the memory sees a
    // stable request even if a requester misbehaves and changes its command
    // mid-access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= P0;
            r_last_gnt <= P1;   // port 0 wins the first contest after reset
            r_rw       <= RD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            if (w_take) begin
                r_gnt      <= w_pick_gnt;
                r_last_gnt <= w_pick_gnt;
                r_rw       <= w_sel_rw;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
            end

            if (r_state == ISSUE) begin
                r_cnt <= CNT_ONE;
            end else if ((r_state == WAIT) && !w_lat_hit) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            // Only the granted port's register moves, and only on reads.
            if ((r_state == WAIT) && w_lat_hit && (r_rw == RD)) begin
                if (r_gnt == P0) begin
                    r_p0_rdata <= mem_rdata;
                end else begin
                    r_p1_rdata <= mem_rdata;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Outside ISSUE/WAIT every memory line is parked at zero; a zero mem_rw in
    // particular guarantees no stray write.
    assign mem_e     = w_mem_en;
    assign mem_rw    = w_mem_en ? r_rw    : RD;
    assign mem_addr  = w_mem_en ? r_addr  : '0;
    assign mem_wdata = w_mem_en ? r_wdata : '0;

    assign p0_done   = w_done && (r_gnt == P0);
    assign p1_done   = w_done && (r_gnt == P1);
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter with a MEM_LAT-deep memory model.
//   Build with ARB_ROUND_ROBIN_EN defined to exercise round-robin expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LAT     = MEM_LAT + 2;   // IDLE sample -> done

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              p0_req, p0_rw, p0_done;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_rw, p1_done;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              mem_e, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_rw     (p0_rw),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rdata  (p0_rdata),
        .p0_done   (p0_done),
        .p1_req    (p1_req),
        .p1_rw     (p1_rw),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_rdata  (p1_rdata),
        .p1_done   (p1_done),
        .mem_e     (mem_e),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- memory
    // Read data appears MEM_LAT cycles after the address is presented; writes
    // commit on the clock edge that sees mem_e && mem_rw.
    logic [DATA_W-1:0] dev_mem  [DEPTH];
    logic [DATA_W-1:0] dev_pipe [MEM_LAT];
    bit                dev_loaded = 1'b0;

    always @(posedge clk) begin
        if (!dev_loaded) begin
            for (int i = 0; i < DEPTH; i++) dev_mem[i] = 32'h1000_0000 | i;
            dev_mem[5] = 32'hDEAD_BEEF;
            dev_loaded = 1'b1;
        end
        dev_pipe[0] <= (mem_e && (mem_rw == RD)) ? dev_mem[mem_addr] : 32'h0BAD_0BAD;
        for (int i = 1; i < MEM_LAT; i++) dev_pipe[i] <= dev_pipe[i-1];
        if (mem_e && (mem_rw == WR)) dev_mem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = dev_pipe[MEM_LAT-1];

    // ------------------------------------------------------------- utilities
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic done_of(input int p);
        return (p == 0) ? p0_done : p1_done;
    endfunction

    function automatic logic [DATA_W-1:0] rdata_of(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic drive(input int p, input logic req, input logic rw,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            p0_req = req; p0_rw = rw; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_rw = rw; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic set_req(input int p, input logic req);
        if (p == 0) p0_req = req; else p1_req = req;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"},   {p0_done, p1_done, mem_e, mem_rw}, 4'b0000);
        check({tag, "_addr"},  mem_addr,  '0);
        check({tag, "_wdata"}, mem_wdata, '0);
        check({tag, "_rd0"},   p0_rdata,  '0);
        check({tag, "_rd1"},   p1_rdata,  '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
    endtask

    // ------------------------------------------------------ single accesses
    typedef struct {
        int                port;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t              vecs[8];
    logic [DATA_W-1:0] exp_rd[2];

    // Called on a negedge while the arbiter is idle.
    task automatic run_single(input vec_t v);
        int c0;
        bit seen;
        int other;
        c0    = cyc;
        other = 1 - v.port;
        seen  = 1'b0;
        drive(v.port, 1'b1, v.rw, v.addr, v.wdata);
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (cyc == c0 + 1 || cyc == c0 + 2) begin
                check("mem_e",    mem_e,    1'b1);
                check("mem_rw",   mem_rw,   v.rw);
                check("mem_addr", mem_addr, v.addr);
                if (v.rw == WR) check("mem_wdata", mem_wdata, v.wdata);
            end
            check("other_done", done_of(other), 1'b0);
            if (done_of(v.port)) begin
                seen = 1'b1;
                check("done_latency", cyc - c0, LAT);
                check("done_mem_idle", {mem_e, mem_rw}, 2'b00);
                if (v.rw == RD) exp_rd[v.port] = v.exp_rdata;
                check("own_rdata",   rdata_of(v.port), exp_rd[v.port]);
                check("other_rdata", rdata_of(other),  exp_rd[other]);
                set_req(v.port, 1'b0);
            end
        end
        check("done_seen", seen, 1'b1);
        @(negedge clk);
        check("done_width", done_of(v.port), 1'b0);
    endtask

    // ------------------------------------------------- multi-access sequences
    int                exp_port_q[$];
    int                exp_off_q[$];
    logic [DATA_W-1:0] exp_dat_q[$];

    localparam logic [ADDR_W-1:0] SEQ_A0 = 10'h005;
    localparam logic [ADDR_W-1:0] SEQ_A1 = 10'h001;
    localparam logic [DATA_W-1:0] SEQ_D0 = 32'hDEAD_BEEF;
    localparam logic [DATA_W-1:0] SEQ_D1 = 32'h1000_0001;

    task automatic expect_done(input int p, input int off);
        exp_port_q.push_back(p);
        exp_off_q.push_back(off);
        exp_dat_q.push_back((p == 0) ? SEQ_D0 : SEQ_D1);
    endtask

    // Port 0 / port 1 hold req high for n0 / n1 back-to-back reads.
    task automatic run_seq(input string tag, input int n0, input int n1);
        int c0;
        int left[2];
        int idx;
        c0      = cyc;
        left[0] = n0;
        left[1] = n1;
        idx     = 0;
        if (n0 > 0) drive(0, 1'b1, RD, SEQ_A0, '0);
        if (n1 > 0) drive(1, 1'b1, RD, SEQ_A1, '0);
        for (int k = 0; k < 60 && (left[0] > 0 || left[1] > 0); k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (done_of(p)) begin
                    if (idx < exp_port_q.size()) begin
                        check({tag, "_port"},  p,           exp_port_q[idx]);
                        check({tag, "_cycle"}, cyc - c0,    exp_off_q[idx]);
                        check({tag, "_rdata"}, rdata_of(p), exp_dat_q[idx]);
                    end else begin
                        check({tag, "_extra"}, idx, exp_port_q.size());
                    end
                    idx++;
                    if (left[p] > 0) begin
                        left[p]--;
                        if (left[p] == 0) set_req(p, 1'b0);
                    end
                end
            end
        end
        check({tag, "_count"}, idx, exp_port_q.size());
        @(negedge clk);
        check({tag, "_quiet"}, {p0_done, p1_done}, 2'b00);
        exp_port_q.delete();
        exp_off_q.delete();
        exp_dat_q.delete();
    endtask

    // ------------------------------------------------ random reference model
    // Transaction-level view: the arbiter is free on any cycle after the
    // previous completion; a grant on free cycle t completes at t + LAT.
    logic [DATA_W-1:0] m_mem[DEPTH];
    logic [DATA_W-1:0] m_rd[2];
    int                m_done_at;
    int                m_gnt;
    int                m_last;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wd;
    bit                pend[2];
    int                gap[2];

    function automatic logic [ADDR_W-1:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 10'h005;
            1:       return 10'h3FF;
            2:       return 10'h000;
            3:       return 10'h001;
            default: return ADDR_W'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic new_cmd(input int p);
        drive(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    endtask

    task automatic run_random(input int n_issue, input int n_cycles);
        bit          exp_done[2];
        bit          issue_en;
        int          g;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = dev_mem[i];
        m_rd[0]   = '0;
        m_rd[1]   = '0;
        m_done_at = -1;
        m_last    = 1;
        m_gnt     = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            gap[p]  = $urandom_range(0, 3);
        end
        for (int i = 0; i < n_cycles; i++) begin
            issue_en = (i < n_issue);
            // expected outputs for this cycle
            exp_done[0] = 1'b0;
            exp_done[1] = 1'b0;
            if (cyc == m_done_at) begin
                exp_done[m_gnt] = 1'b1;
                if (m_rw == RD) m_rd[m_gnt] = m_mem[m_addr];
                else            m_mem[m_addr] = m_wd;
            end
            check("rand_done0", p0_done,  exp_done[0]);
            check("rand_done1", p1_done,  exp_done[1]);
            check("rand_rd0",   p0_rdata, m_rd[0]);
            check("rand_rd1",   p1_rdata, m_rd[1]);
            // requesters react to the completion they actually saw
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    if (done_of(p)) begin
                        if (issue_en && $urandom_range(0, 3) == 0) begin
                            new_cmd(p);
                        end else begin
                            set_req(p, 1'b0);
                            pend[p] = 1'b0;
                            gap[p]  = $urandom_range(0, 4);
                        end
                    end
                end else if (gap[p] > 0) begin
                    gap[p]--;
                end else if (issue_en) begin
                    new_cmd(p);
                    pend[p] = 1'b1;
                end
            end
            // grant decision for requests visible on a free cycle
            if (cyc > m_done_at && (p0_req || p1_req)) begin
                if (p0_req && p1_req) g = (RR_MODE && m_last == 0) ? 1 : 0;
                else                  g = p1_req ? 1 : 0;
                m_gnt     = g;
                m_last    = g;
                m_rw      = (g == 1) ? p1_rw    : p0_rw;
                m_addr    = (g == 1) ? p1_addr  : p0_addr;
                m_wd      = (g == 1) ? p1_wdata : p0_wdata;
                m_done_at = cyc + LAT;
            end
            @(negedge clk);
        end
        check("rand_drain0", pend[0], 1'b0);
        check("rand_drain1", pend[1], 1'b0);
    endtask

    // ------------------------------------------------------------------ test
    initial begin
        vecs[0] = '{0, RD, 10'h005, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1, WR, 10'h3FF, 32'h1234_5678, 32'h0};
        vecs[2] = '{1, RD, 10'h3FF, 32'h0,         32'h1234_5678};
        vecs[3] = '{1, RD, 10'h005, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{0, WR, 10'h000, 32'hA5A5_A5A5, 32'h0};
        vecs[5] = '{0, RD, 10'h3FF, 32'h0,         32'h1234_5678};
        vecs[6] = '{1, RD, 10'h000, 32'h0,         32'hA5A5_A5A5};
        vecs[7] = '{0, RD, 10'h001, 32'h0,         32'h1000_0001};

        reset = 1'b1;
        drive(0, 1'b0, RD, '0, '0);
        drive(1, 1'b0, RD, '0, '0);
        repeat (3) @(negedge clk);
        check_quiet("por");
        reset = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // first access issued in cycle 10
        while (cyc < 10) @(negedge clk);
        foreach (vecs[i]) run_single(vecs[i]);

        // contests and back-to-back reads
        do_reset();
        expect_done(0, LAT);
        expect_done(1, 2 * LAT + 1);
        run_seq("contest1", 1, 1);

        if (RR_MODE) begin
            expect_done(0, LAT);
            expect_done(1, 2 * LAT + 1);
            expect_done(0, 3 * LAT + 2);
            expect_done(1, 4 * LAT + 3);
        end else begin
            expect_done(0, LAT);
            expect_done(0, 2 * LAT + 1);
            expect_done(1, 3 * LAT + 2);
            expect_done(1, 4 * LAT + 3);
        end
        run_seq("contest3", 2, 2);

        expect_done(0, LAT);
        expect_done(0, 2 * LAT + 1);
        expect_done(0, 3 * LAT + 2);
        run_seq("b2b", 3, 0);

        // reset during the WAIT phase of a port 1 write
        drive(1, 1'b1, WR, 10'h010, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        check("abort_wait_mem", {mem_e, mem_rw}, 2'b11);
        reset = 1'b1;
        set_req(1, 1'b0);
        @(negedge clk);
        check_quiet("abort");
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_done", {p0_done, p1_done}, 2'b00);
        end
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        run_single(vecs[0]);

        // randomized traffic from both ports
        do_reset();
        run_random(420, 500);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
